contador_ctrl: RTL

Controller and sequencer for the per-class word counters of the packet datapath. It runs the counting phases (reset, init, idle, active) and steers each valid 10-bit word to one of four class counters selected by data_in[9:8]. It also serves a single read port through which the checker or host requests a class count. It sits beside the datapath FIFOs and consumes the same data_in/valid stream that the probador drives.

---
 rtl/contador_ctrl_if.sv | 24 ++
 rtl/contador_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/contador_ctrl_if.sv
// Data stream and read-port signals shared between the word source
// (probador / host) and the contador_ctrl class-counter controller.
interface contador_ctrl_if #(
  parameter int COUNT_W = 5
);
  logic               valid_in;
  logic [9:0]         data_in;
  logic               req;
  logic [1:0]         idx;
  logic [COUNT_W-1:0] count_out;
  logic               valid_out;

  // Side that drives words and read requests
  modport master (
    output valid_in, data_in, req, idx,
    input  count_out, valid_out
  );

  // Counter controller side
  modport slave (
    input  valid_in, data_in, req, idx,
    output count_out, valid_out
  );
endinterface

// File: rtl/contador_ctrl.sv
// Sequencer for the four per-class word counters of the packet datapath.
// Runs the RESET/INIT/IDLE/ACTIVE phases, counts each valid word into the
// counter chosen by data_in[9:8], and serves a one-cycle-latency read port.
module contador_ctrl #(
  parameter int COUNT_W  = 5,
  parameter int IDLE_GAP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  contador_ctrl_if.slave   bus,
  output logic             idle,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_t;

  // Gap counter is 4 bits wide, enough for IDLE_GAP up to 15
  localparam logic [3:0] GAP_LIMIT = 4'(IDLE_GAP);

  state_t             state_reg, state_next;
  logic [3:0]         gap_reg, gap_next;
  logic [3:0]         gap_inc;
  logic               count_en;
  logic               clear_cnt;
  logic               read_en;
  logic [1:0]         class_sel;
  logic [3:0]         hit;
  logic [COUNT_W-1:0] cnt_reg [4];
  logic [COUNT_W-1:0] count_out_reg;
  logic               valid_out_reg;

  assign class_sel = bus.data_in[9:8];
  assign gap_inc   = gap_reg + 4'd1;

  // State and gap counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_RESET;
      gap_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      gap_reg   <= gap_next;
    end
  end

  // Next-state, gap tracking, count and read enables; init wins over all else
  always_comb begin
    state_next = state_reg;
    gap_next   = gap_reg;
    count_en   = 1'b0;
    clear_cnt  = 1'b0;
    read_en    = 1'b0;
    case (state_reg)
      ST_RESET: begin
        state_next = ST_INIT;
        gap_next   = 4'd0;
      end
      ST_INIT: begin
        clear_cnt = 1'b1;
        gap_next  = 4'd0;
        if (!init) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        read_en  = bus.req;
        gap_next = 4'd0;
        if (init) begin
          state_next = ST_INIT;
          clear_cnt  = 1'b1;
        end else if (bus.valid_in) begin
          state_next = ST_ACTIVE;
          count_en   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        read_en = bus.req;
        if (init) begin
          state_next = ST_INIT;
          clear_cnt  = 1'b1;
          gap_next   = 4'd0;
        end else if (bus.valid_in) begin
          count_en = 1'b1;
          gap_next = 4'd0;
        end else if (gap_inc == GAP_LIMIT) begin
          state_next = ST_IDLE;
          gap_next   = 4'd0;
        end else begin
          gap_next = gap_inc;
        end
      end
      default: begin
        state_next = ST_RESET;
        gap_next   = 4'd0;
      end
    endcase
  end

  // One-hot increment strobe per class counter
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hit
      assign hit[gi] = count_en && (class_sel == 2'(gi));
    end
  endgenerate

  // Class counters: cleared in INIT, wrap modulo 2^COUNT_W when counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (clear_cnt)   cnt_reg[i] <= '0;
        else if (hit[i]) cnt_reg[i] <= cnt_reg[i] + COUNT_W'(1);
      end
    end
  end

  // Read port: samples the pre-increment count, valid_out pulses per accepted req
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_out_reg <= '0;
      valid_out_reg <= 1'b0;
    end else begin
      valid_out_reg <= read_en;
      if (read_en) count_out_reg <= cnt_reg[bus.idx];
    end
  end

  assign bus.count_out = count_out_reg;
  assign bus.valid_out = valid_out_reg;
  assign idle          = (state_reg == ST_IDLE);
  assign state         = state_reg;

endmodule
